hack_rom_loader: RTL and testbench

//  Wishbone slave inside caravel_hack_soc; sits directly downstream of the wishbone

---
 rtl/hack_rom_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_hack_rom_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: Wishbone-fed word FIFO that streams Hack program words to SPI SRAM.
// Optional macro HACK_ROM_LOADER_IRQ_EN builds the load-done pulse on irq_o.
module hack_rom_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        hack_rst_o,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        irq_o
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TMR_W   = $clog2(2 * CLK_DIV);
  localparam int unsigned FRAME_W = 48;
  localparam int unsigned BIT_W   = 6;
  localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
  localparam logic [3:0]  OFF_CTRL   = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;
  localparam logic [3:0]  OFF_DATA   = 4'h8;
  localparam logic [3:0]  OFF_ADDR   = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic                 cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
  logic                 ack_q, ack_d, load_q, load_d;
  logic [31:0]          dat_q, dat_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 addr_wr_q, addr_wr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [15:0]          mem_q [FIFO_DEPTH];

  logic                 req, fifo_empty, fifo_full, busy, pop, push, accept, data_wr;
  logic [3:0]           off;
  logic [31:0]          status;
  logic [FRAME_W-1:0]   frame;
  logic                 in_unused;

  assign in_unused  = ^{wbs_sel_i, wbs_dat_i[31:16]};
  assign off        = wbs_adr_i[3:0];
  assign req        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy       = (state_q != S_IDLE) | ~fifo_empty;
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  assign data_wr    = wbs_we_i & (off == OFF_DATA);
  // A DATA write into a full FIFO is held off until the FSM frees a slot.
  assign accept     = req & ~ack_q & ~(data_wr & fifo_full & ~pop);
  assign push       = accept & data_wr;
  assign status     = {20'b0, 4'(count_q), 5'b0, fifo_full, fifo_empty, busy};
  assign frame      = {SPI_CMD_WRITE, 24'({addr_q, 1'b0}), mem_q[rd_ptr_q]};

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ack_d     = 1'b0;
    dat_d     = '0;
    load_d    = load_q;
    addr_d    = addr_q;
    addr_wr_d = addr_wr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d   = S_SHIFT;
          cs_n_d    = 1'b0;
          sck_d     = 1'b0;
          tmr_d     = '0;
          bit_d     = '0;
          sr_d      = frame;
          mosi_d    = frame[FRAME_W-1];
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          addr_wr_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (tmr_q == TMR_W'(CLK_DIV - 1)) begin
          tmr_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_d = S_GAP;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              // A CPU write to ADDR during this transfer replaces the increment.
              if (!addr_wr_q) addr_d = addr_q + ADDR_W'(1);
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
              mosi_d = sr_q[FRAME_W-2];
            end
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == TMR_W'(2 * CLK_DIV - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      ack_d = 1'b1;
      if (wbs_we_i) begin
        case (off)
          OFF_CTRL: begin
            load_d = wbs_dat_i[0];
            if (wbs_dat_i[1]) begin
              addr_d    = '0;
              addr_wr_d = 1'b1;
            end
          end
          OFF_ADDR: begin
            addr_d    = wbs_dat_i[ADDR_W-1:0];
            addr_wr_d = 1'b1;
          end
          OFF_DATA: wr_ptr_d = wr_ptr_q + PTR_W'(1);
          default: ;
        endcase
      end else begin
        case (off)
          OFF_CTRL:   dat_d = {31'b0, load_q};
          OFF_STATUS: dat_d = status;
          OFF_ADDR:   dat_d = 32'(addr_q);
          default: ;
        endcase
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      load_q    <= 1'b1;
      addr_q    <= '0;
      addr_wr_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      addr_wr_q <= addr_wr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wbs_dat_i[15:0];
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign hack_rst_o = load_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;

`ifdef HACK_ROM_LOADER_IRQ_EN
  // Load-done pulse on the falling edge of busy.
  logic busy_q, irq_q, irq_d;
  assign irq_d = busy_q & ~busy;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      busy_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      busy_q <= busy;
      irq_q  <= irq_d;
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: register vector table plus SPI frame scoreboard.
module tb_hack_rom_loader;

  localparam int unsigned CLK_DIV = 2;
  localparam logic [31:0] BASE    = 32'h3000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, hack_rst, cs_n, sck, mosi, irq;
  logic [31:0] rdat;

  hack_rom_loader dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .hack_rst_o(hack_rst),
    .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [47:0] sb[$];
  logic [15:0] exp_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: sample MOSI on each rising SCK, compare when cs_n rises.
  logic [47:0] mon_frame;
  int mon_bits = 0, mon_len = 0, irq_cnt = 0, bad_ack = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, req_seen = 1'b0;

  always @(posedge clk) req_seen <= cyc & stb;

  always @(negedge clk) begin
    if (ack && !req_seen) bad_ack++;
    if (irq) irq_cnt++;
    if (rst) begin
      mon_bits = 0; mon_len = 0; prev_sck = 1'b0; prev_cs = 1'b1;
    end else begin
      if (!cs_n) begin
        mon_len++;
        if (sck && !prev_sck) begin
          mon_frame = {mon_frame[46:0], mosi};
          mon_bits++;
        end
      end
      if (cs_n && !prev_cs) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_frame", 64'(mon_frame), 64'hDEAD);
        end else begin
          check("spi_frame", 64'(mon_frame), 64'(sb.pop_front()));
        end
        check("spi_bits", 64'(mon_bits), 64'd48);
        check("cs_low_cycles", 64'(mon_len), 64'(96 * CLK_DIV));
        mon_bits = 0; mon_len = 0;
      end
      prev_sck = sck; prev_cs = cs_n;
    end
  end

  task automatic wb_access(input logic [3:0] off, input logic w, input logic [31:0] d,
                           output logic [31:0] rd, output int waited);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); wdat = d;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!ack && waited < 5000);
    check("ack_seen", 64'(ack), 64'd1);
    rd = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_single_cycle", 64'(ack), 64'd0);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] rd; int w;
    wb_access(off, 1'b1, d, rd, w);
    if (off == 4'hC) exp_addr = d[15:0];
  endtask

  task automatic rd_check(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] rd; int w;
    wb_access(off, 1'b0, 32'h0, rd, w);
    check(name, 64'(rd), 64'(exp));
  endtask

  task automatic push_word(input logic [15:0] d, output int waited);
    logic [31:0] rd;
    sb.push_back({8'h02, 24'({exp_addr, 1'b0}), d});
    exp_addr = exp_addr + 16'd1;
    wb_access(4'h8, 1'b1, 32'(d), rd, waited);
  endtask

  task automatic wait_idle();
    logic [31:0] rd; int w; int n;
    n = 0;
    do begin
      wb_access(4'h4, 1'b0, 32'h0, rd, w);
      n++;
    end while (rd[0] && n < 3000);
    check("wait_idle_busy", 64'(rd[0]), 64'd0);
  endtask

  task automatic wait_bits(input int nbits);
    int n;
    n = 0;
    while (mon_bits < nbits && n < 5000) begin
      @(posedge clk); n++;
    end
    check("wait_bits_reached", 64'(mon_bits >= nbits), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  off;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_rst;
  } vec_t;
  vec_t vecs[13];

  initial begin
    logic [31:0] rd;
    int w;
    logic exp_irq;

    vecs[0]  = '{4'hC, 1'b1, 32'h0000_1234, 32'h0,         1'b1};
    vecs[1]  = '{4'hC, 1'b0, 32'h0,         32'h0000_1234, 1'b1};
    vecs[2]  = '{4'h0, 1'b1, 32'h0000_0003, 32'h0,         1'b1};
    vecs[3]  = '{4'hC, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[4]  = '{4'h0, 1'b0, 32'h0,         32'h0000_0001, 1'b1};
    vecs[5]  = '{4'hC, 1'b1, 32'hFFFF_00A5, 32'h0,         1'b1};
    vecs[6]  = '{4'hC, 1'b0, 32'h0,         32'h0000_00A5, 1'b1};
    vecs[7]  = '{4'h4, 1'b1, 32'h0000_00FF, 32'h0,         1'b1};
    vecs[8]  = '{4'h4, 1'b0, 32'h0,         32'h0000_0002, 1'b1};
    vecs[9]  = '{4'h8, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{4'h0, 1'b1, 32'h0000_0000, 32'h0,         1'b0};
    vecs[11] = '{4'h0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[12] = '{4'h0, 1'b1, 32'h0000_0001, 32'h0,         1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_hack_rst", 64'(hack_rst), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_ack", 64'(ack), 64'd0);
    rd_check("rst_status", 4'h4, 32'h0000_0002);
    rd_check("rst_addr", 4'hC, 32'h0);

    // Register vector table
    for (int i = 0; i < 13; i++) begin
      wb_access(vecs[i].off, vecs[i].w, vecs[i].d, rd, w);
      check($sformatf("vec%0d_ack_latency", i), 64'(w), 64'd1);
      if (!vecs[i].w) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_hack_rst", i), 64'(hack_rst), 64'(vecs[i].exp_rst));
    end

    // Single word at ADDR=0x10
    wr(4'hC, 32'h10);
    push_word(16'hABCD, w);
    wait_idle();
    rd_check("addr_after_one", 4'hC, 32'h11);

    // FIFO full stall; first word is already shifting when the rest arrive
    wr(4'hC, 32'h40);
    push_word(16'h1000, w);
    for (int i = 1; i < 9; i++) push_word(16'h1000 + 16'(i), w);
    rd_check("status_full", 4'h4, 32'h0000_0805);
    push_word(16'h1009, w);
    check("full_write_stalled", 64'(w > 2 * CLK_DIV), 64'd1);
    rd_check("status_push_pop_same", 4'h4, 32'h0000_0805);
    wait_idle();
    rd_check("addr_after_ten", 4'hC, 32'h4A);

    // Address wrap
    wr(4'hC, 32'hFFFF);
    push_word(16'h5555, w);
    push_word(16'hAAAA, w);
    wait_idle();
    rd_check("addr_after_wrap", 4'hC, 32'h1);

    // ADDR write and CTRL.load clear during a transfer
    wr(4'hC, 32'h0100);
    push_word(16'h0F0F, w);
    wait_bits(8);
    wr(4'h0, 32'h0);
    #1;
    check("load_clear_hack_rst", 64'(hack_rst), 64'd0);
    check("load_clear_cs_low", 64'(cs_n), 64'd0);
    wr(4'hC, 32'h0200);
    push_word(16'hF0F0, w);
    wait_idle();
    rd_check("addr_after_busy_write", 4'hC, 32'h0201);
    wr(4'h0, 32'h1);

    // IRQ on load completion
    irq_cnt = 0;
    wr(4'hC, 32'h0300);
    push_word(16'h0001, w);
    push_word(16'h0002, w);
    push_word(16'h0003, w);
    wait_idle();
    repeat (4) @(posedge clk);
`ifdef HACK_ROM_LOADER_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    check("irq_pulse_cycles", 64'(irq_cnt), 64'(exp_irq));

    // Reset mid-transfer at bit 20
    wr(4'hC, 32'h0030);
    push_word(16'h1111, w);
    push_word(16'h2222, w);
    push_word(16'h3333, w);
    wait_bits(20);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_cs_n", 64'(cs_n), 64'd1);
    check("midrst_sck", 64'(sck), 64'd0);
    check("midrst_hack_rst", 64'(hack_rst), 64'd1);
    sb.delete();
    exp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    rd_check("midrst_status", 4'h4, 32'h0000_0002);
    rd_check("midrst_addr", 4'hC, 32'h0);
    repeat (300) @(posedge clk);
    #1;
    check("midrst_no_transfer", 64'(cs_n), 64'd1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    check("ack_only_with_request", 64'(bad_ack), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
